// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM image loader: FSM states, error codes,
// and header-field indices.
package rom_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_AH,
    ST_AL,
    ST_LH,
    ST_LL,
    ST_CHK,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_CSUM  = 2'd2;

  // Position of each latched header byte, counted from the byte after SYNC.
  localparam int unsigned FLD_ADDR_H = 0;
  localparam int unsigned FLD_ADDR_L = 1;
  localparam int unsigned FLD_LEN_H  = 2;
  localparam int unsigned FLD_LEN_L  = 3;

  function automatic logic state_ready(state_t s);
    return s inside {ST_IDLE, ST_AH, ST_AL, ST_LH, ST_LL, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream link (valid/ready) feeding the ROM loader.
interface rom_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/rom_loader_csum.sv
// 8-bit running checksum for loader frames; ok flags that the incoming byte
// brings the total to zero.
module rom_loader_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic       ok
);
  logic [7:0] acc;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= '0;
    end else if (add) begin
      acc <= acc + din;
    end
  end

  assign ok = ((acc + din) == 8'h00);

endmodule

// File: rtl/rom_loader.sv
// Run-time writer for the 8Kx8 program ROM: parses framed bytes and drives the write port.
// Optional trailing checksum byte enabled by defining ROM_LOADER_CSUM_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  rom_loader_if.slave       link,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned SUM_W = ADDR_W + 4;

  state_t            state;
  logic [7:0]        hdr [FLD_ADDR_H:FLD_LEN_L];
  logic [15:0]       hdr_addr;
  logic [15:0]       len;
  logic [SUM_W-1:0]  end_addr;
  logic              range_bad;
  logic              xfer;
  logic [ADDR_W-1:0] cur;
  logic [15:0]       rem;

  assign link.s_ready = state_ready(state);
  assign xfer         = link.s_valid & link.s_ready;

  assign hdr_addr  = {hdr[FLD_ADDR_H], hdr[FLD_ADDR_L]};
  assign len       = {hdr[FLD_LEN_H], hdr[FLD_LEN_L]};
  // Widened sum so base + len can never wrap past the memory top.
  assign end_addr  = SUM_W'(hdr_addr[ADDR_W-1:0]) + SUM_W'(len);
  assign range_bad = ((hdr_addr >> ADDR_W) != 16'd0) ||
                     (end_addr > (SUM_W'(1) << ADDR_W));

`ifdef ROM_LOADER_CSUM_EN
  logic csum_ok;

  rom_loader_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (xfer && (state == ST_IDLE)),
    .add   (xfer && (state inside {ST_AH, ST_AL, ST_LH, ST_LL, ST_DATA})),
    .din   (link.s_data),
    .ok    (csum_ok)
  );

  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hdr       <= '{default: '0};
      cur       <= '0;
      rem       <= '0;
      mem_waddr <= '0;
      mem_data  <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer && (link.s_data == SYNC_BYTE)) begin
            busy     <= 1'b1;
            err_code <= ERR_NONE;
            state    <= ST_AH;
          end
        end
        ST_AH: if (xfer) begin hdr[FLD_ADDR_H] <= link.s_data; state <= ST_AL; end
        ST_AL: if (xfer) begin hdr[FLD_ADDR_L] <= link.s_data; state <= ST_LH; end
        ST_LH: if (xfer) begin hdr[FLD_LEN_H]  <= link.s_data; state <= ST_LL; end
        ST_LL: if (xfer) begin hdr[FLD_LEN_L]  <= link.s_data; state <= ST_CHK; end
        ST_CHK: begin
          if (range_bad) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_RANGE;
          end else if (len == 16'd0) begin
            state <= ST_TAIL;
            done  <= (ST_TAIL == ST_DONE);
          end else begin
            state <= ST_DATA;
            cur   <= hdr_addr[ADDR_W-1:0];
            rem   <= len;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_waddr <= cur;
            mem_data  <= DATA_W'(link.s_data);
            cur       <= cur + 1'b1;
            rem       <= rem - 1'b1;
            if (rem == 16'd1) begin
              state <= ST_TAIL;
              done  <= (ST_TAIL == ST_DONE);
            end
          end
        end
`ifdef ROM_LOADER_CSUM_EN
        ST_CSUM: begin
          if (xfer) begin
            if (csum_ok) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_ERR;
              err      <= 1'b1;
              err_code <= ERR_CSUM;
            end
          end
        end
`endif
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
